// File: rtl/vga_pkg.sv
// Shared VGA constants, move-controller state encoding and button bit positions.
package vga_pkg;
  localparam int H_VALID = 640;
  localparam int V_VALID = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } move_state_e;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;
endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchronizer plus consecutive-disagreement counter for one raw button.
module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn_raw,
  output logic btn_db
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // Any agreeing cycle restarts the count, so short glitches never flip btn_db.
      if (sync2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_move_ctrl.sv
// Debounced button-driven object mover: one clamped position update per vsync
// rising edge, with SLOW/FAST acceleration after a sustained hold.
module vga_move_ctrl #(
  parameter int DEB_CYCLES   = 20,
  parameter int H_VALID      = vga_pkg::H_VALID,
  parameter int V_VALID      = vga_pkg::V_VALID,
  parameter int OBJ_SIZE     = 16,
  parameter int STEP         = 2,
  parameter int ACCEL_FRAMES = 8,
  parameter int X_INIT       = 312,
  parameter int Y_INIT       = 232
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       vsync,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic [3:0] btn_db,
  output logic       frame_tick,
  output logic       edge_hit,
  output logic       fast
);
  import vga_pkg::*;

  localparam int                 HW    = $clog2(ACCEL_FRAMES + 1);
  localparam logic signed [10:0] X_MAX = 11'(H_VALID - OBJ_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(V_VALID - OBJ_SIZE);

  logic [3:0] btn_raw;
  assign btn_raw = {up, down, left, right};

  for (genvar g = 0; g < 4; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .btn_raw   (btn_raw[g]),
      .btn_db    (btn_db[g])
    );
  end

  logic vs_s1, vs_s2, vs_s2_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_s2_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= vsync;
      vs_s2      <= vs_s1;
      vs_s2_d    <= vs_s2;
      frame_tick <= vs_s2 & ~vs_s2_d;
    end
  end

  move_state_e       state;
  logic [HW-1:0]     hold_cnt;
  logic              mv_r, mv_l, mv_d, mv_u, moving;
  logic signed [10:0] step_s, dx_off, dy_off, nx_raw, ny_raw;
  logic [9:0]        nx, ny;
  logic              hit_x, hit_y;

  // Opposing presses cancel on each axis.
  assign mv_r   = btn_db[BTN_RIGHT] & ~btn_db[BTN_LEFT];
  assign mv_l   = btn_db[BTN_LEFT]  & ~btn_db[BTN_RIGHT];
  assign mv_d   = btn_db[BTN_DOWN]  & ~btn_db[BTN_UP];
  assign mv_u   = btn_db[BTN_UP]    & ~btn_db[BTN_DOWN];
  assign moving = mv_r | mv_l | mv_d | mv_u;

  assign step_s = (state == FAST) ? 11'(2 * STEP) : 11'(STEP);
  assign dx_off = mv_r ? step_s : (mv_l ? -step_s : 11'sd0);
  assign dy_off = mv_d ? step_s : (mv_u ? -step_s : 11'sd0);
  assign nx_raw = $signed({1'b0, obj_x}) + dx_off;
  assign ny_raw = $signed({1'b0, obj_y}) + dy_off;

  always_comb begin
    nx    = nx_raw[9:0];
    hit_x = 1'b0;
    if (nx_raw < 0) begin
      nx    = '0;
      hit_x = 1'b1;
    end else if (nx_raw > X_MAX) begin
      nx    = X_MAX[9:0];
      hit_x = 1'b1;
    end
  end

  always_comb begin
    ny    = ny_raw[9:0];
    hit_y = 1'b0;
    if (ny_raw < 0) begin
      ny    = '0;
      hit_y = 1'b1;
    end else if (ny_raw > Y_MAX) begin
      ny    = Y_MAX[9:0];
      hit_y = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      obj_x    <= 10'(X_INIT);
      obj_y    <= 10'(Y_INIT);
      edge_hit <= 1'b0;
    end else begin
      edge_hit <= 1'b0;
      if (frame_tick) begin
        obj_x    <= nx;
        obj_y    <= ny;
        edge_hit <= hit_x | hit_y;
        case (state)
          IDLE: if (moving) begin
            state    <= SLOW;
            hold_cnt <= HW'(1);
          end
          SLOW: if (!moving) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            if (int'(hold_cnt) < ACCEL_FRAMES) hold_cnt <= hold_cnt + 1'b1;
            // Step doubles from the next frame onward; this update used the SLOW step.
            if (int'(hold_cnt) + 1 >= ACCEL_FRAMES) state <= FAST;
          end
          FAST: if (!moving) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
          default: begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign fast = (state == FAST);
endmodule

// File: tb/tb_vga_move_ctrl.sv
// Directed self-checking bench for vga_move_ctrl.
module tb_vga_move_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n, up, down, left, right, vsync;
  logic [9:0] obj_x, obj_y;
  logic [3:0] btn_db;
  logic       frame_tick, edge_hit, fast;

  int n_pass = 0, n_total = 0, tick_cnt = 0;
  logic       fr_tick, fr_eh, fr_eh2, fr_fast;
  logic [9:0] fr_x0, fr_x, fr_y;

  vga_move_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .up(up), .down(down), .left(left),
    .right(right), .vsync(vsync), .obj_x(obj_x), .obj_y(obj_y), .btn_db(btn_db),
    .frame_tick(frame_tick), .edge_hit(edge_hit), .fast(fast)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) if (frame_tick === 1'b1) tick_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
    repeat (30) @(negedge sys_clk);
  endtask

  // One vsync pulse; captures position at the tick cycle, after the update, and one cycle later.
  task automatic do_frame();
    int n = 0;
    vsync = 1'b1;
    fr_tick = 1'b0;
    while (!fr_tick && n < 8) begin
      @(negedge sys_clk);
      n++;
      if (frame_tick === 1'b1) fr_tick = 1'b1;
    end
    if (!fr_tick) begin
      $display("FAIL frame_tick_timeout: no pulse within 8 cycles");
      n_total++;
    end
    fr_x0 = obj_x;
    @(negedge sys_clk);
    fr_x = obj_x; fr_y = obj_y; fr_eh = edge_hit; fr_fast = fast;
    @(negedge sys_clk);
    fr_eh2 = edge_hit;
    vsync = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; vsync = 1'b0; up = 0; down = 0; left = 0; right = 0;
    repeat (3) @(negedge sys_clk);
    n_total++;
    if ({obj_x, obj_y, btn_db, frame_tick, edge_hit, fast} !== {10'd312, 10'd232, 4'd0, 3'b000})
      $display("FAIL reset: x=%0d y=%0d db=%b ft=%b eh=%b f=%b, want 312 232 0000 0 0 0",
               obj_x, obj_y, btn_db, frame_tick, edge_hit, fast);
    else n_pass++;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_idle_frames();
    int t0 = tick_cnt;
    for (int i = 0; i < 5; i++) do_frame();
    n_total++;
    if (tick_cnt - t0 !== 5) $display("FAIL idle_ticks: got %0d want 5", tick_cnt - t0);
    else n_pass++;
    n_total++;
    if ({obj_x, obj_y} !== {10'd312, 10'd232})
      $display("FAIL idle_pos: x=%0d y=%0d want 312 232", obj_x, obj_y);
    else n_pass++;
  endtask

  task automatic test_debounce_and_update();
    logic seen = 1'b0;
    right = 1'b1;
    repeat (10) begin @(negedge sys_clk); if (btn_db[0]) seen = 1'b1; end
    right = 1'b0;
    repeat (25) begin @(negedge sys_clk); if (btn_db[0]) seen = 1'b1; end
    n_total++;
    if (seen !== 1'b0) $display("FAIL glitch: btn_db[0] got 1 want 0");
    else n_pass++;
    right = 1'b1;
    repeat (15) @(negedge sys_clk);
    n_total++;
    if (btn_db !== 4'b0000) $display("FAIL deb_early: btn_db=%b want 0000", btn_db);
    else n_pass++;
    repeat (10) @(negedge sys_clk);
    n_total++;
    if (btn_db !== 4'b0001) $display("FAIL deb_set: btn_db=%b want 0001", btn_db);
    else n_pass++;
    do_frame();
    n_total++;
    if ({fr_x0, fr_x, fr_eh, fr_fast} !== {10'd312, 10'd314, 1'b0, 1'b0})
      $display("FAIL first_move: x@tick=%0d x@+1=%0d eh=%b f=%b want 312 314 0 0",
               fr_x0, fr_x, fr_eh, fr_fast);
    else n_pass++;
  endtask

  task automatic test_accel();
    int exp_x;
    for (int i = 2; i <= 12; i++) begin
      do_frame();
      exp_x = (i <= 8) ? 312 + 2 * i : 328 + 4 * (i - 8);
      n_total++;
      if (fr_x !== 10'(exp_x) || fr_fast !== (i >= 8))
        $display("FAIL accel_f%0d: x=%0d fast=%b want %0d %b", i, fr_x, fr_fast, exp_x, i >= 8);
      else n_pass++;
    end
    set_btns(0, 0, 0, 0);
    do_frame();
    n_total++;
    if (fr_x !== 10'd344 || fr_fast !== 1'b0)
      $display("FAIL release: x=%0d fast=%b want 344 0", fr_x, fr_fast);
    else n_pass++;
  endtask

  task automatic test_clamp_x();
    set_btns(0, 0, 0, 1);
    do_frame();                          // SLOW step -> 346
    set_btns(0, 0, 0, 0);
    do_frame();                          // back to IDLE
    set_btns(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) do_frame();   // 362, enters FAST
    for (int i = 0; i < 65; i++) do_frame();  // 362 + 65*4 = 622
    n_total++;
    if (obj_x !== 10'd622 || fast !== 1'b1) $display("FAIL reach_622: x=%0d fast=%b want 622 1", obj_x, fast);
    else n_pass++;
    do_frame();
    n_total++;
    if ({fr_x, fr_eh, fr_eh2} !== {10'd624, 1'b1, 1'b0})
      $display("FAIL clamp_x: x=%0d eh=%b eh_next=%b want 624 1 0", fr_x, fr_eh, fr_eh2);
    else n_pass++;
    do_frame();
    n_total++;
    if ({fr_x, fr_eh} !== {10'd624, 1'b1}) $display("FAIL clamp_rehit: x=%0d eh=%b want 624 1", fr_x, fr_eh);
    else n_pass++;
    set_btns(0, 0, 1, 1);
    do_frame();
    do_frame();
    n_total++;
    if ({fr_x, fr_y, fr_eh, fr_fast} !== {10'd624, 10'd232, 1'b0, 1'b0})
      $display("FAIL cancel_lr: x=%0d y=%0d eh=%b fast=%b want 624 232 0 0", fr_x, fr_y, fr_eh, fr_fast);
    else n_pass++;
    set_btns(0, 0, 0, 0);
  endtask

  task automatic test_clamp_y();
    set_btns(1, 0, 0, 0);
    do_frame();                          // 230
    set_btns(0, 0, 0, 0);
    do_frame();
    set_btns(1, 0, 0, 0);
    for (int i = 0; i < 61; i++) do_frame();  // 230-16=214, then 214-53*4=2
    n_total++;
    if (obj_y !== 10'd2 || fast !== 1'b1) $display("FAIL reach_y2: y=%0d fast=%b want 2 1", obj_y, fast);
    else n_pass++;
    do_frame();
    n_total++;
    if ({fr_y, fr_eh} !== {10'd0, 1'b1}) $display("FAIL clamp_y: y=%0d eh=%b want 0 1", fr_y, fr_eh);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fast();
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    n_total++;
    if ({obj_x, obj_y, btn_db, edge_hit, fast} !== {10'd312, 10'd232, 4'd0, 2'b00})
      $display("FAIL async_reset: x=%0d y=%0d db=%b eh=%b f=%b want 312 232 0000 0 0",
               obj_x, obj_y, btn_db, edge_hit, fast);
    else n_pass++;
    up = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    set_btns(1, 0, 0, 1);
    do_frame();
    n_total++;
    if ({fr_x, fr_y, fr_fast} !== {10'd314, 10'd230, 1'b0})
      $display("FAIL diag1: x=%0d y=%0d fast=%b want 314 230 0", fr_x, fr_y, fr_fast);
    else n_pass++;
    do_frame();
    n_total++;
    if ({fr_x, fr_y, fr_fast} !== {10'd316, 10'd228, 1'b0})
      $display("FAIL diag2: x=%0d y=%0d fast=%b want 316 228 0", fr_x, fr_y, fr_fast);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_debounce_and_update();
    test_accel();
    test_clamp_x();
    test_clamp_y();
    test_reset_mid_fast();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_move_ctrl.md
Name: vga_move_ctrl

Overview:
- Controller that sequences the on-screen object position consumed by the picture generator.
- Debounces the four direction buttons and applies at most one position update per video frame, on the rising edge of vsync.
- Clamps the object to the visible area and accelerates after a sustained hold.
- Sits between the raw board buttons/vsync and the picture generator's obj_x/obj_y inputs.

Parameters:
- DEB_CYCLES, 20, consecutive sys_clk cycles a synchronized button must disagree with its debounced value before that value flips (≥2).
- H_VALID, 640, visible width in pixels.
- V_VALID, 480, visible height in pixels.
- OBJ_SIZE, 16, object edge length in pixels.
- STEP, 2, pixels moved per frame in SLOW state.
- ACCEL_FRAMES, 8, consecutive moving frames before entering FAST (≥1).
- X_INIT, 312, reset x position.
- Y_INIT, 232, reset y position.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- up  in  1  raw button, active-high, asynchronous.
- down  in  1  raw button, active-high, asynchronous.
- left  in  1  raw button, active-high, asynchronous.
- right  in  1  raw button, active-high, asynchronous.
- vsync  in  1  field sync from the VGA timing generator; treated as asynchronous.
- obj_x  out  10  object top-left x.
- obj_y  out  10  object top-left y.
- btn_db  out  4  debounced buttons {up,down,left,right}.
- frame_tick  out  1  one-cycle pulse per vsync rising edge.
- edge_hit  out  1  one-cycle pulse when an update was clamped.
- fast  out  1  high while in FAST state.

Behaviour:
- Reset: sys_rst_n is asynchronous active-low; the clock is sys_clk. While reset is asserted:
  - obj_x = X_INIT, obj_y = Y_INIT.
  - btn_db = 0, frame_tick = 0, edge_hit = 0, fast = 0.
  - All synchronizers, debounce counters and the FSM are cleared; FSM = IDLE.
- Synchronization: every button and vsync passes through a 2-FF synchronizer.
- Debounce, per button:
  - The counter increments while the synchronized value ≠ btn_db bit, and clears when they agree.
  - On reaching DEB_CYCLES−1, the btn_db bit toggles and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes btn_db.
- Frame tick:
  - frame_tick is registered and equals sync2 & ~sync2_d.
  - It is high for exactly one cycle, 3 sys_clk edges after the first edge that samples vsync high.
- Direction resolution, from btn_db:
  - dx = +1 if right & ~left; −1 if left & ~right; else 0.
  - dy = +1 if down & ~up; −1 if up & ~down; else 0.
  - Opposing presses cancel.
- Update:
  - Occurs on the edge following the frame_tick cycle; obj_x/obj_y change exactly 1 cycle after frame_tick.
  - step = STEP in SLOW, 2*STEP in FAST.
  - Arithmetic uses 11-bit signed intermediates.
  - nx = obj_x + dx*step, clamped to [0, H_VALID−OBJ_SIZE].
  - ny = obj_y + dy*step, clamped to [0, V_VALID−OBJ_SIZE].
- edge_hit: pulses for 1 cycle, coincident with the update, if either axis was clamped (requested value outside range). An object resting at a limit with the button held re-pulses every frame.
- FSM, evaluated only on the update cycle. hold_cnt saturates at ACCEL_FRAMES.
  - IDLE: (dx|dy)≠0 → SLOW with hold_cnt=1, and moves by STEP in this same update.
  - SLOW: (dx|dy)=0 → IDLE. Otherwise hold_cnt+1; when hold_cnt reaches ACCEL_FRAMES → FAST (the switch applies to the next frame's step).
  - FAST: (dx|dy)=0 → IDLE, clearing hold_cnt.
  - A direction change while moving does not leave SLOW/FAST.
  - fast = (state==FAST).
- No position change between frame ticks. Button activity without vsync edges never moves the object.
- vsync stuck high or low: no ticks and no motion.
- Mid-operation reset: immediate return to the reset values above, including mid-debounce and mid-FAST.

Decomposition:
- Shared package vga_pkg holds:
  - the H_VALID/V_VALID constants already used by the timing generator;
  - the state enum IDLE=0, SLOW=1, FAST=2;
  - the button index constants BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0.
- One sub-module, btn_debounce: 2-FF sync + counter, parameter DEB_CYCLES, instantiated 4×.
- The vsync synchronizer, FSM and position datapath live in vga_move_ctrl.

Test Plan:
- Reset → obj_x=312, obj_y=232, btn_db=0, fast=0. Then 5 vsync pulses with no buttons → position unchanged and 5 frame_tick pulses.
- right glitch high for 10 cycles, then 25 cycles held → btn_db[0] stays 0 through the glitch, sets after ≥20 stable cycles. Next frame → obj_x=314; obj_x updates exactly 1 cycle after frame_tick.
- right held 12 frames → obj_x advances +2 for frames 1–8, then +4 per frame. fast rises after the 8th update; release → IDLE, fast=0.
- Start obj_x=622, right held → obj_x clamps at 624 with an edge_hit pulse that frame, and edge_hit pulses on each subsequent frame. left+right held together → no x motion, state stays IDLE.
- up held from obj_y=1 → obj_y=0 and edge_hit=1. Also up+right → diagonal step on both axes in one update.
- Assert sys_rst_n=0 mid-FAST → outputs return to reset values asynchronously. After release, motion restarts in SLOW.
